// File: rtl/muller_c_sequencer.sv
// Drives one N-input Muller C-element through set/hold/clear/hold phases.
// It checks the acknowledge and hysteresis of each iteration and keeps the pass/fail counts.
module muller_c_sequencer #(
   parameter int N_IN        = 2,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 15,
   parameter int HOLD_CYC    = 8,
   parameter int CNT_W       = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] iter_cnt,
   output logic [N_IN-1:0]  c_in,
   input  logic             c_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             timeout_seen,
   output logic             hold_err_seen,
   output logic [2:0]       state_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SET   = 3'd1;
   localparam logic [2:0] S_HOLD1 = 3'd2;
   localparam logic [2:0] S_CLR   = 3'd3;
   localparam logic [2:0] S_HOLD0 = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam int KW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam int HW = $clog2(HOLD_CYC + 1);

   logic [2:0]             state;
   logic [2:0]             nxt;
   logic [KW-1:0]          k;
   logic [KW-1:0]          k_nxt;
   logic [WW-1:0]          w;
   logic [HW-1:0]          h;
   logic [CNT_W-1:0]       iter_lat;
   logic [CNT_W-1:0]       iter_num;
   logic                   fail_bit;
   logic [SYNC_STAGES-1:0] sync;
   logic                   c_sync;
   logic                   sat;
   logic                   hold_end;
   logic                   last_iter;
   logic                   go;
   logic                   fail_now;

   assign c_sync  = sync[SYNC_STAGES-1];
   assign state_o = state;

   // Input pattern for a given phase and rotation index.
   function automatic logic [N_IN-1:0] drive(
      input logic [2:0]    s,
      input logic [KW-1:0] kk
   );
      logic [N_IN-1:0] one;
      one = N_IN'(1) << kk;
      case (s)
         S_SET:   return '1;
         S_HOLD1: return ~one;
         S_HOLD0: return one;
         default: return '0;
      endcase
   endfunction

   always_comb begin
      nxt       = state;
      k_nxt     = k;
      sat       = (w == WW'(TIMEOUT));
      hold_end  = (h == HW'(HOLD_CYC - 1));
      last_iter = ((iter_num + CNT_W'(1)) == iter_lat);
      go        = (state == S_IDLE) && start && !abort;
      fail_now  = fail_bit || c_sync;
      unique case (state)
         S_IDLE: begin
            if (go) begin
               nxt   = (iter_cnt == '0) ? S_DONE : S_SET;
               k_nxt = '0;
            end
         end
         S_SET: begin
            if (c_sync || sat) nxt = S_HOLD1;
         end
         S_HOLD1: begin
            if (hold_end) nxt = S_CLR;
         end
         S_CLR: begin
            if (!c_sync || sat) nxt = S_HOLD0;
         end
         S_HOLD0: begin
            if (hold_end) begin
               nxt   = last_iter ? S_DONE : S_SET;
               k_nxt = (k == KW'(N_IN - 1)) ? '0 : k + KW'(1);
            end
         end
         S_DONE: nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
      if (abort && state != S_IDLE) begin
         nxt   = S_IDLE;
         k_nxt = k;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= S_IDLE;
         c_in          <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass_cnt      <= '0;
         fail_cnt      <= '0;
         timeout_seen  <= 1'b0;
         hold_err_seen <= 1'b0;
         k             <= '0;
         w             <= '0;
         h             <= '0;
         iter_lat      <= '0;
         iter_num      <= '0;
         fail_bit      <= 1'b0;
         sync          <= '0;
      end else begin
         sync[0] <= c_out;
         for (int i = 1; i < SYNC_STAGES; i++)
            sync[i] <= sync[i-1];

         state <= nxt;
         k     <= k_nxt;
         c_in  <= drive(nxt, k_nxt);
         busy  <= nxt inside {S_SET, S_HOLD1, S_CLR, S_HOLD0};
         done  <= (nxt == S_DONE);

         // Phase timers restart on every state change.
         if (nxt != state) begin
            w <= '0;
            h <= '0;
         end else begin
            if (!sat)      w <= w + WW'(1);
            if (!hold_end) h <= h + HW'(1);
         end

         if (go) begin
            pass_cnt      <= '0;
            fail_cnt      <= '0;
            timeout_seen  <= 1'b0;
            hold_err_seen <= 1'b0;
            iter_lat      <= iter_cnt;
            iter_num      <= '0;
            fail_bit      <= 1'b0;
         end

         // An aborted cycle leaves all scoring untouched.
         if (!abort) begin
            unique case (state)
               S_SET: begin
                  if (!c_sync && sat) begin
                     fail_bit     <= 1'b1;
                     timeout_seen <= 1'b1;
                  end
               end
               S_CLR: begin
                  if (c_sync && sat) begin
                     fail_bit     <= 1'b1;
                     timeout_seen <= 1'b1;
                  end
               end
               S_HOLD1: begin
                  if (!c_sync) begin
                     fail_bit      <= 1'b1;
                     hold_err_seen <= 1'b1;
                  end
               end
               S_HOLD0: begin
                  if (c_sync) begin
                     fail_bit      <= 1'b1;
                     hold_err_seen <= 1'b1;
                  end
                  if (hold_end) begin
                     if (fail_now) begin
                        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
                     end else begin
                        if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
                     end
                     iter_num <= iter_num + CNT_W'(1);
                     fail_bit <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_muller_c_sequencer.sv
// Randomized bench for muller_c_sequencer against behavioural C-element models.
// Expected scores come from the element type and its delay, not from the FSM.
module tb_muller_c_sequencer;

   localparam int N_IN    = 2;
   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 15;
   localparam int SYNC    = 2;

   logic             clock = 1'b0;
   logic             reset;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] iter_cnt;
   logic [N_IN-1:0]  c_in;
   logic             c_out;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] pass_cnt;
   logic [CNT_W-1:0] fail_cnt;
   logic             timeout_seen;
   logic             hold_err_seen;
   logic [2:0]       state_o;

   muller_c_sequencer dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .abort        (abort),
      .iter_cnt     (iter_cnt),
      .c_in         (c_in),
      .c_out        (c_out),
      .busy         (busy),
      .done         (done),
      .pass_cnt     (pass_cnt),
      .fail_cnt     (fail_cnt),
      .timeout_seen (timeout_seen),
      .hold_err_seen(hold_err_seen),
      .state_o      (state_o)
   );

   always #5 clock = ~clock;

   // Element models: 0 ideal C (delay dly), 1 stuck-0, 2 stuck-1, 3 AND gate.
   int          mode = 0;
   int          dly  = 0;
   logic        csr  = 1'b0;
   logic [31:0] hist = '0;
   logic        cst;

   assign cst = (&c_in) ? 1'b1 : (c_in == '0) ? 1'b0 : csr;

   always @(posedge clock) begin
      csr  <= cst;
      hist <= {hist[30:0], cst};
   end

   assign c_out = (mode == 1) ? 1'b0 :
                  (mode == 2) ? 1'b1 :
                  (mode == 3) ? &c_in :
                  (dly == 0)  ? cst : hist[dly-1];

   int tests = 0;
   int fails = 0;
   int ndone;
   int nbusy;
   logic [N_IN-1:0] prev;
   logic [N_IN-1:0] cq[$];
   logic [N_IN-1:0] eq[$];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
      if (done) ndone++;
      if (busy) nbusy++;
      if (c_in !== prev) begin
         cq.push_back(c_in);
         prev = c_in;
      end
   endtask

   task automatic run(input int m, input int d, input int n);
      int ep, ef, eto, ehe, budget, bad;
      logic [N_IN-1:0] one;
      mode = m;
      dly  = d;
      repeat (25) tick();
      cq.delete();
      prev  = c_in;
      ndone = 0;
      nbusy = 0;
      iter_cnt = CNT_W'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
      budget = n * 60 + 30;
      while (ndone == 0 && budget > 0) begin
         tick();
         budget--;
      end
      tick();
      tick();
      ep = 0; ef = 0; eto = 0; ehe = 0;
      if (n > 0) begin
         case (m)
            0: if (d + SYNC <= TIMEOUT) ep = n;
               else begin ef = n; eto = 1; end
            1: begin ef = n; eto = 1; ehe = 1; end
            2: begin ef = n; eto = 1; ehe = 1; end
            default: begin ef = n; ehe = 1; end
         endcase
      end
      check($sformatf("done_once m%0d n%0d", m, n), ndone, 1);
      check("busy_end", busy, 0);
      check($sformatf("pass m%0d d%0d n%0d", m, d, n), pass_cnt, ep);
      check($sformatf("fail m%0d d%0d n%0d", m, d, n), fail_cnt, ef);
      check("timeout_seen", timeout_seen, eto);
      if (m != 0 || d + SYNC <= TIMEOUT)
         check("hold_err_seen", hold_err_seen, ehe);
      if (n == 0) check("busy_never", nbusy, 0);
      if (m == 0 && d + SYNC <= TIMEOUT && n > 0) begin
         eq.delete();
         for (int i = 0; i < n; i++) begin
            one = N_IN'(1) << (i % N_IN);
            eq.push_back('1);
            eq.push_back(~one);
            eq.push_back('0);
            eq.push_back(one);
         end
         eq.push_back('0);
         check("cin_len", cq.size(), eq.size());
         bad = 0;
         for (int i = 0; i < eq.size() && i < cq.size(); i++)
            if (cq[i] !== eq[i]) bad++;
         check("cin_seq", bad, 0);
      end
   endtask

   initial begin
      int lat, reached, cyc;
      reset = 1'b1; start = 1'b0; abort = 1'b0; iter_cnt = '0;
      prev = '0; ndone = 0; nbusy = 0;
      repeat (3) tick();
      check("rst_state", state_o, 0);
      check("rst_cin", c_in, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cnt", {pass_cnt, fail_cnt}, 0);
      check("rst_flags", {timeout_seen, hold_err_seen}, 0);
      reset = 1'b0;

      run(0, 0, 3);
      run(1, 0, 2);
      run(3, 0, 4);
      run(2, 0, 2);
      run(0, 13, 2);
      run(0, 14, 1);

      // Zero iterations: done shortly after start, busy never rises.
      mode = 0; dly = 0;
      repeat (5) tick();
      ndone = 0; nbusy = 0; lat = 0;
      iter_cnt = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 1;
      while (ndone == 0 && lat < 6) begin
         tick();
         lat++;
      end
      check("zero_done_lat", (ndone == 1 && lat <= 2), 1);
      tick();
      check("zero_busy", nbusy, 0);
      check("zero_cnt", {pass_cnt, fail_cnt}, 0);

      for (int r = 0; r < 8; r++) begin
         int m, d, n;
         m = $urandom_range(0, 3);
         d = (m == 0) ? $urandom_range(0, 13) : 0;
         n = $urandom_range(0, 5);
         run(m, d, n);
      end

      // Abort in HOLD1 of iteration 2, with stray starts mid-run.
      mode = 0; dly = 0;
      repeat (25) tick();
      ndone = 0;
      iter_cnt = CNT_W'(5);
      start = 1'b1;
      tick();
      start = 1'b0;
      reached = 0;
      cyc = 0;
      while (!reached && cyc < 200) begin
         if (cyc == 10 || cyc == 45) begin
            iter_cnt = '0;
            start = 1'b1;
         end
         tick();
         start = 1'b0;
         cyc++;
         if (state_o == 3'd2 && pass_cnt == 1) reached = 1;
      end
      check("abort_reach", reached, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_state", state_o, 0);
      check("abort_cin", c_in, 0);
      check("abort_busy", busy, 0);
      check("abort_pass", pass_cnt, 1);
      check("abort_fail", fail_cnt, 0);
      repeat (10) tick();
      check("abort_nodone", ndone, 0);

      // Abort beats start in the same idle cycle.
      iter_cnt = CNT_W'(3);
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      tick();
      check("abort_start_busy", busy, 0);
      check("abort_start_state", state_o, 0);
      check("abort_start_keep", pass_cnt, 1);

      // Reset during CLR.
      iter_cnt = CNT_W'(3);
      start = 1'b1;
      tick();
      start = 1'b0;
      reached = 0;
      cyc = 0;
      while (!reached && cyc < 200) begin
         tick();
         cyc++;
         if (state_o == 3'd3) reached = 1;
      end
      check("clr_reach", reached, 1);
      reset = 1'b1;
      tick();
      check("mrst_state", state_o, 0);
      check("mrst_cin", c_in, 0);
      check("mrst_busy_done", {busy, done}, 0);
      check("mrst_cnt", {pass_cnt, fail_cnt}, 0);
      check("mrst_flags", {timeout_seen, hold_err_seen}, 0);
      reset = 1'b0;
      run(0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
